mem_bank_arbiter: RTL

// Round-robin arbiter/sequencer sharing one synchronous memory bank between NUM_REQ requesters
// (the four cache ways' refill/write-back ports). Accepts one request at a time, drives the bank's
// rd/wr/addr/data pins for one cycle, waits for the bank's data_ready, returns read data plus a
// one-cycle ack to the winner. Sits between the cache-way controllers and the memory bank.
//

---
 rtl/mem_bank_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_bank_arbiter.sv
// mem_bank_arbiter: round-robin sequencer sharing one synchronous memory bank
// between NUM_REQ requesters. One access at a time: IDLE -> ISSUE -> WAIT -> DONE.
//
// Ports:
//   clock, reset            clock (posedge) and asynchronous active-low reset
//   req/req_we              per-requester request level and write select
//   req_addr/req_wdata      flattened per-requester address / write data
//   req_ack/req_err         one-hot completion pulse, err qualifies a timeout
//   req_rdata               read data of the last successful read
//   grant_id/busy           current/last winner index, FSM not idle
//   mem_rd/mem_wr           one-cycle bank strobes
//   mem_addr/mem_wdata      bank address / write data, held from ISSUE on
//   mem_rdata/mem_ready     bank read data and data-ready
module mem_bank_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*WORD_SIZE-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic                            req_err,
  output logic [WORD_SIZE-1:0]            req_rdata,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic                            mem_rd,
  output logic                            mem_wr,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [WORD_SIZE-1:0]            mem_wdata,
  input  logic [WORD_SIZE-1:0]            mem_rdata,
  input  logic                            mem_ready
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_q, last_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic                  err_q, err_d;
  logic [WORD_SIZE-1:0]  rdata_q, rdata_d;
  logic                  busy_q, busy_d;

  // Unflatten per-requester address and write data
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [WORD_SIZE-1:0]  wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*WORD_SIZE +: WORD_SIZE];
  end

  // Round-robin search: first set request starting just after the last winner
  logic          win_vld;
  logic [GW-1:0] win_idx;
  logic [GW-1:0] cand;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = GW'((32'(last_q) + off) % NUM_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    cnt_d   = cnt_q;
    ack_d   = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = win_idx;
          we_d    = req_we[win_idx];
          addr_d  = addr_arr[win_idx];
          wdata_d = wdata_arr[win_idx];
          rd_d    = ~req_we[win_idx];
          wr_d    = req_we[win_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // mem_ready takes priority over a timeout on the same edge
        if (mem_ready) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          ack_d[grant_q] = 1'b1;
          state_d        = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(TIMEOUT)) begin
            ack_d[grant_q] = 1'b1;
            err_d          = 1'b1;
            state_d        = DONE;
          end
        end
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ack   = ack_q;
  assign req_err   = err_q;
  assign req_rdata = rdata_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
